// File: rtl/uart_frame_pkg.sv
// Shared UART word-frame definitions: tag constants, sync byte, scheduler
// state encoding and the byte encoder used by the transmit side.
package uart_frame_pkg;

  localparam logic [1:0] TAG_SYNC  = 2'b00;
  localparam logic [1:0] TAG_HI    = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b10;
  localparam logic [1:0] TAG_LO    = 2'b11;
  localparam logic [7:0] SYNC_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD,
    ST_WAIT
  } sched_state_e;

  // Byte index 0 is the optional sync byte; 1..3 carry the word, high part first.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] w);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = {TAG_HI, w[15:12], 2'b00};
      2'd2:    b = {TAG_MID, w[11:6]};
      default: b = {TAG_LO, w[5:0]};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner (modulo N_REQ)
// and advances its pointer only when the caller accepts the grant.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int IDXW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             update_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDXW-1:0]  grant_idx_o,
  output logic             any_o
);

  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_d;
  logic [IDXW-1:0] cand;
  int              sum;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    sum         = 0;
    cand        = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      sum  = (int'(ptr_q) + k) % int'(N_REQ);
      cand = IDXW'(sum);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        grant_idx_o = cand;
      end
    end
    if (any_o) grant_o[grant_idx_o] = 1'b1;
  end

  assign ptr_d = (update_i && any_o) ? grant_idx_o : ptr_q;

  // Pointer starts at the last requester so requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IDXW'(N_REQ - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_word_tx_scheduler.sv
// Shares one byte-wide UART transmitter between N_REQ word sources, sending
// each granted 16-bit word as a tagged 3-byte frame with optional sync byte.
module uart_word_tx_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] word,
  output logic [N_REQ-1:0]    ack,
  output logic [7:0]          tx_din,
  output logic                tx_start,
  input  logic                tx_done_tick,
  output logic                busy
);

  localparam int IDXW = $clog2(N_REQ);

  sched_state_e     state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic             tx_start_q, tx_start_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IDXW-1:0]  arb_idx;
  logic             arb_any;
  logic             arb_update;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .update_i   (arb_update),
    .grant_o    (arb_grant),
    .grant_idx_o(arb_idx),
    .any_o      (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    arb_update = 1'b0;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_GRANT;
      ST_GRANT: begin
        if (arb_any) begin
          arb_update = 1'b1;
          word_d     = word[{arb_idx, 4'b0000} +: 16];
          ack_d      = arb_grant;
          byte_idx_d = SYNC_EN ? 2'd0 : 2'd1;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        tx_din_d   = frame_byte(byte_idx_q, word_q);
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          if (byte_idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset mid-frame lands in IDLE, where a late tx_done_tick has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      byte_idx_q <= '0;
      ack_q      <= '0;
      tx_din_q   <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      ack_q      <= ack_d;
      tx_din_q   <= tx_din_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign ack      = ack_q;
  assign tx_din   = tx_din_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_word_tx_scheduler.sv
// Scoreboard bench for uart_word_tx_scheduler: one instance with the sync byte,
// one without, each driven by a UART model that answers 10 cycles after start.
module tb_uart_word_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reqA = '0, reqB = '0;
  logic [63:0] wordA = '0, wordB = '0;
  logic [3:0]  ackA, ackB;
  logic [7:0]  txDinA, txDinB;
  logic        txStartA, txStartB, busyA, busyB;
  logic        modelDoneA = 1'b0, modelDoneB = 1'b0;
  logic        manualDoneA = 1'b0;
  logic        modelEnA = 1'b1;
  wire         doneA = modelDoneA | manualDoneA;
  wire         doneB = modelDoneB;
  int          cntA = 0, cntB = 0;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] expByteA[$];
  logic [3:0] expAckA[$];
  logic [7:0] expByteB[$];
  logic [3:0] expAckB[$];

  always #5 clk = ~clk;

  uart_word_tx_scheduler #(.N_REQ(4), .SYNC_EN(1'b1)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .word(wordA), .ack(ackA),
    .tx_din(txDinA), .tx_start(txStartA), .tx_done_tick(doneA), .busy(busyA)
  );

  uart_word_tx_scheduler #(.N_REQ(4), .SYNC_EN(1'b0)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .word(wordB), .ack(ackB),
    .tx_din(txDinB), .tx_start(txStartB), .tx_done_tick(doneB), .busy(busyB)
  );

  // UART transmitter models: done pulse one full cycle, 10 cycles after start.
  always @(negedge clk) begin
    modelDoneA <= 1'b0;
    if (rst) cntA <= 0;
    else if (txStartA && modelEnA) cntA <= 10;
    else if (cntA > 0) begin
      cntA <= cntA - 1;
      if (cntA == 1) modelDoneA <= 1'b1;
    end
  end

  always @(negedge clk) begin
    modelDoneB <= 1'b0;
    if (rst) cntB <= 0;
    else if (txStartB) cntB <= 10;
    else if (cntB > 0) begin
      cntB <= cntB - 1;
      if (cntB == 1) modelDoneB <= 1'b1;
    end
  end

  function automatic logic [7:0] expByte(input int idx, input logic [15:0] w);
    case (idx)
      0:       return 8'h00;
      1:       return {2'b01, w[15:12], 2'b00};
      2:       return {2'b10, w[11:6]};
      default: return {2'b11, w[5:0]};
    endcase
  endfunction

  task automatic pushFrameA(input int g, input logic [15:0] w);
    expAckA.push_back(4'(1 << g));
    for (int i = 0; i < 4; i++) expByteA.push_back(expByte(i, w));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdleA(input int budget, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < budget) begin
      @(negedge clk);
      t++;
      if (!busyA && expByteA.size() == 0 && expAckA.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: pops and compares whenever a DUT emits tx_start or ack.
  task automatic scoreboard();
    logic [7:0] eb;
    logic [3:0] ea;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (txStartA) begin
          compared++;
          if (expByteA.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL byteA: got tx_din=%h, required no tx_start", txDinA);
          end else begin
            eb = expByteA.pop_front();
            if (txDinA !== eb) begin
              mismatched++;
              $display("[TB] FAIL byteA: got %h, required %h", txDinA, eb);
            end
          end
        end
        if (ackA !== 4'b0000) begin
          compared++;
          if (expAckA.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL ackA: got %b, required none", ackA);
          end else begin
            ea = expAckA.pop_front();
            if (ackA !== ea) begin
              mismatched++;
              $display("[TB] FAIL ackA: got %b, required %b", ackA, ea);
            end
          end
        end
        if (txStartB) begin
          compared++;
          if (expByteB.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL byteB: got tx_din=%h, required no tx_start", txDinB);
          end else begin
            eb = expByteB.pop_front();
            if (txDinB !== eb) begin
              mismatched++;
              $display("[TB] FAIL byteB: got %h, required %h", txDinB, eb);
            end
          end
        end
        if (ackB !== 4'b0000) begin
          compared++;
          if (expAckB.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL ackB: got %b, required none", ackB);
          end else begin
            ea = expAckB.pop_front();
            if (ackB !== ea) begin
              mismatched++;
              $display("[TB] FAIL ackB: got %b, required %b", ackB, ea);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    compared++;
    if ({ackA, txStartA, txDinA, busyA} !== 14'd0) begin
      mismatched++;
      $display("[TB] FAIL resetA: got ack=%b start=%b din=%h busy=%b, required all 0", ackA, txStartA, txDinA, busyA);
    end
    compared++;
    if ({ackB, txStartB, txDinB, busyB} !== 14'd0) begin
      mismatched++;
      $display("[TB] FAIL resetB: got ack=%b start=%b din=%h busy=%b, required all 0", ackB, txStartB, txDinB, busyB);
    end
  endtask

  task automatic test_single();
    int t = 0;
    bit ok;
    expAckA.push_back(4'b0100);
    expByteA.push_back(8'h00);
    expByteA.push_back(8'h68);
    expByteA.push_back(8'hAF);
    expByteA.push_back(8'hCD);
    wordA[47:32] = 16'hABCD;
    reqA = 4'b0100;
    while (ackA === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    reqA = 4'b0000;
    compared++;
    if (t != 2) begin
      mismatched++;
      $display("[TB] FAIL ack_latency: got %0d cycles, required 2", t);
    end
    waitIdleA(200, ok);
    compared++;
    if (!ok || busyA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_drain: got busy=%b left=%0d, required busy=0 left=0", busyA, expByteA.size());
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int t = 0;
    bit ok;
    doReset();
    wordA = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    pushFrameA(0, 16'h0001);
    pushFrameA(1, 16'h0002);
    pushFrameA(2, 16'h0003);
    pushFrameA(3, 16'h0004);
    pushFrameA(0, 16'h0001);
    reqA = 4'b1111;
    while (n < 5 && t < 800) begin
      @(negedge clk);
      t++;
      if (ackA !== 4'b0000) n++;
    end
    reqA = 4'b0000;
    waitIdleA(200, ok);
    compared++;
    if (!ok || n != 5) begin
      mismatched++;
      $display("[TB] FAIL round_robin: got %0d grants left=%0d, required 5 left=0", n, expByteA.size());
    end
  endtask

  task automatic test_no_sync();
    int t = 0;
    expAckB.push_back(4'b0010);
    expByteB.push_back(8'h7C);
    expByteB.push_back(8'hBF);
    expByteB.push_back(8'hFF);
    wordB[31:16] = 16'hFFFF;
    reqB = 4'b0010;
    while (ackB === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    reqB = 4'b0000;
    t = 0;
    while ((busyB || expByteB.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    compared++;
    if (busyB !== 1'b0 || expByteB.size() != 0 || expAckB.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL no_sync_drain: got busy=%b left=%0d, required busy=0 left=0", busyB, expByteB.size());
    end
  endtask

  task automatic test_word_change();
    int t = 0;
    bit ok;
    doReset();
    pushFrameA(0, 16'h1234);
    wordA[15:0] = 16'h1234;
    reqA = 4'b0001;
    while (ackA === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    reqA = 4'b0000;
    @(negedge clk);
    wordA[15:0] = 16'h5678;
    waitIdleA(200, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL word_change_drain: got left=%0d, required 0", expByteA.size());
    end
  endtask

  task automatic test_reset_midframe();
    int t;
    bit ok;
    modelEnA = 1'b0;
    wordA[15:0] = 16'h0BEE;
    expAckA.push_back(4'b0001);
    for (int i = 0; i < 3; i++) expByteA.push_back(expByte(i, 16'h0BEE));
    pushFrameA(0, 16'h0BEE);
    reqA = 4'b0001;
    for (int b = 0; b < 3; b++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!txStartA && t < 20);
      compared++;
      if (!txStartA) begin
        mismatched++;
        $display("[TB] FAIL midframe_start%0d: got no tx_start, required one", b);
      end
      repeat (3) @(negedge clk);
      if (b < 2) begin
        manualDoneA = 1'b1;
        @(negedge clk);
        manualDoneA = 1'b0;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if ({ackA, txStartA, txDinA, busyA} !== 14'd0) begin
      mismatched++;
      $display("[TB] FAIL midframe_reset: got ack=%b start=%b din=%h busy=%b, required all 0", ackA, txStartA, txDinA, busyA);
    end
    manualDoneA = 1'b1;
    @(negedge clk);
    manualDoneA = 1'b0;
    modelEnA = 1'b1;
    compared++;
    if (txStartA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stale_done: got tx_start=%b, required 0", txStartA);
    end
    t = 0;
    while (ackA === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    reqA = 4'b0000;
    waitIdleA(200, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL resend_drain: got left=%0d, required 0", expByteA.size());
    end
  endtask

  task automatic test_spurious_done();
    reqA = 4'b0000;
    @(negedge clk);
    manualDoneA = 1'b1;
    @(negedge clk);
    manualDoneA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if ({txStartA, ackA, busyA} !== 6'd0) begin
        mismatched++;
        $display("[TB] FAIL spurious_done: got start=%b ack=%b busy=%b, required 0", txStartA, ackA, busyA);
      end
    end
  endtask

  initial begin
    $display("[TB] starting uart_word_tx_scheduler bench");
    fork
      scoreboard();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_no_sync();
    test_word_change();
    test_reset_midframe();
    test_spurious_done();
    repeat (5) @(negedge clk);
    compared++;
    if (expByteA.size() != 0 || expAckA.size() != 0 || expByteB.size() != 0 || expAckB.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL leftover: got %0d/%0d/%0d/%0d pending, required 0", expByteA.size(), expAckA.size(), expByteB.size(), expAckB.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_word_tx_scheduler.md
Name: uart_word_tx_scheduler

Overview:
- Shares one 8-bit UART transmitter between N_REQ requesters. Each requester offers a 16-bit word, such as a ball or player coordinate.
- Round-robin grant: the granted word is latched and serialised into the tagged 3-byte frame decoded on the receive side:
  - tag 01: bits [15:12]
  - tag 10: bits [11:6]
  - tag 11: bits [5:0], word valid
- An optional tag-00 sync byte can precede each frame.
- Sits between the game-state logic and uart_tx in the board top.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SYNC_EN, 1, when 1 each frame is preceded by sync byte 8'h00.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req  input  N_REQ  per-requester "word pending" level; held until ack.
- word  input  16*N_REQ  flattened words; requester i occupies word[16*i+15:16*i].
- ack  output  N_REQ  one-cycle pulse to the granted requester when its word is latched.
- tx_din  output  8  byte to UART transmitter; stable from tx_start until tx_done_tick.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_din.
- tx_done_tick  input  1  one-cycle pulse from UART transmitter at end of stop bit.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset is synchronous on rst and applies the following values:
  - ack=0, tx_start=0, tx_din=8'h00, busy=0.
  - state=IDLE, rr_ptr=N_REQ-1, latched word=0, byte index=0.
- Reset mid-frame aborts the frame immediately. The next tx_done_tick is ignored. No ack is re-issued for the aborted word; the requester still holds req, so the word is resent later.
- State machine: IDLE, GRANT, LOAD, WAIT.
  - IDLE: if any req is set, go to GRANT next cycle. Otherwise stay.
  - GRANT, 1 cycle:
    - Select the first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
    - Latch word i, pulse ack[i], set rr_ptr=i.
    - Set byte index = 0 if SYNC_EN, else 1. Go to LOAD.
    - If req dropped to all-zero in the same cycle, return to IDLE with no ack.
  - LOAD, 1 cycle: drive tx_din from the byte index and pulse tx_start. Go to WAIT.
    - 0 -> 8'h00
    - 1 -> {2'b01, w[15:12], 2'b00}
    - 2 -> {2'b10, w[11:6]}
    - 3 -> {2'b11, w[5:0]}
  - WAIT: hold tx_din until tx_done_tick.
    - If byte index < 3: increment and go to LOAD.
    - If byte index = 3: go to IDLE.
- Latency:
  - req rising in IDLE -> ack at cycle +2 (registered).
  - First tx_start at cycle +3.
  - tx_done_tick of the last byte -> next GRANT at +2 cycles at the earliest.
- Fairness: a requester holding req continuously is served at most once per N_REQ frames while others are pending. A single requester with req always high is served back-to-back.
- tx_done_tick outside WAIT is ignored. tx_done_tick coincident with tx_start is impossible by construction, since tx_start is issued only in LOAD.
- req and word changes after ack do not affect the frame in flight.
- Exactly one ack pulse per completed grant; never more than one ack bit set.

Decomposition:
- Shared package or include uart_frame_pkg:
  - tag constants TAG_SYNC=2'b00, TAG_HI=2'b01, TAG_MID=2'b10, TAG_LO=2'b11.
  - SYNC_BYTE=8'h00.
  - state encoding.
- One natural sub-module, rr_arbiter: req, rr_ptr, grant one-hot, grant index, any. Purely combinational plus pointer register; reusable elsewhere.

Test Plan:
- N_REQ=4, SYNC_EN=1, only req[2] high, word[2]=16'hABCD, with a tx model returning done 10 cycles after start.
  - Expect tx_din sequence 8'h00, 8'h68, 8'hAF, 8'hCD; one ack[2] pulse; busy low after last done.
- req=4'b1111 held with words 16'h0001..16'h0004: grant order 0,1,2,3,0, each frame 4 bytes.
- SYNC_EN=0, req[1]=1, word[1]=16'hFFFF: exactly 3 bytes 8'h7C, 8'hBF, 8'hFF.
- Change word[0] from 16'h1234 to 16'h5678 the cycle after ack[0]: transmitted frame still encodes 16'h1234.
- Assert rst during WAIT of byte 2: all outputs return to reset values next cycle and the stale tx_done_tick is ignored. With req still high, a fresh full frame follows.
- Spurious tx_done_tick in IDLE with req=0: no tx_start, no ack, state stays IDLE.
